// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encodings
// and the request legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_RESP = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // True when the request must be rejected without touching memory.
    function automatic logic is_bad_req(input logic store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_B:         bad = 1'b0;
            F3_H:         bad = lane[0];
            F3_W:         bad = (lane != 2'b00);
            F3_BU:        bad = store;
            F3_HU:        bad = store | lane[0];
            default:      bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: merges store data into an old word and
// extracts/extends load data from a read word.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] old_word,
    input  logic [WIDTH-1:0] rd_word,
    input  logic [WIDTH-1:0] wdata,
    input  logic [1:0]       lane,
    input  logic [2:0]       funct3,
    output logic [WIDTH-1:0] merged,
    output logic [WIDTH-1:0] load_data
);

    logic [4:0]        byte_sh;
    logic [4:0]        half_sh;
    logic [WIDTH-1:0]  byte_mask;
    logic [WIDTH-1:0]  half_mask;
    logic [WIDTH-1:0]  rd_byte_w;
    logic [WIDTH-1:0]  rd_half_w;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    assign byte_sh   = {lane, 3'b000};
    assign half_sh   = {lane[1], 4'b0000};
    assign byte_mask = {{(WIDTH-8){1'b0}}, 8'hFF} << byte_sh;
    assign half_mask = {{(WIDTH-16){1'b0}}, 16'hFFFF} << half_sh;
    assign rd_byte_w = rd_word >> byte_sh;
    assign rd_half_w = rd_word >> half_sh;
    assign byte_s    = rd_byte_w[7:0];
    assign half_s    = rd_half_w[15:0];

    always_comb begin
        merged = wdata;
        case (funct3)
            F3_B:    merged = (old_word & ~byte_mask) |
                              ({{(WIDTH-8){1'b0}}, wdata[7:0]} << byte_sh);
            F3_H:    merged = (old_word & ~half_mask) |
                              ({{(WIDTH-16){1'b0}}, wdata[15:0]} << half_sh);
            default: merged = wdata;
        endcase
    end

    always_comb begin
        load_data = rd_word;
        case (funct3)
            F3_B:    load_data = {{(WIDTH-8){byte_s[7]}}, byte_s};
            F3_BU:   load_data = {{(WIDTH-8){1'b0}}, rd_byte_w[7:0]};
            F3_H:    load_data = {{(WIDTH-16){half_s[15]}}, half_s};
            F3_HU:   load_data = {{(WIDTH-16){1'b0}}, rd_half_w[15:0]};
            default: load_data = rd_word;
        endcase
    end

endmodule

// File: rtl/lsu_engine.sv
// Load/store unit: takes byte-addressed core requests and drives a
// word-indexed memory, with read-modify-write for sub-word stores.
module lsu_engine
    import lsu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int ADDR_OFFSET = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_store,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic             resp_err,
    output logic [WIDTH-1:0] resp_data,
    output logic             mem_read_en,
    output logic             mem_write_en,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_write_data,
    input  logic [WIDTH-1:0] mem_out_data
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] addr_r;
    logic [WIDTH-1:0] wdata_r;
    logic [2:0]       funct3_r;
    logic             store_r;
    logic [WIDTH-1:0] old_r;
    logic [WIDTH-1:0] resp_data_r;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] load_data;
    logic             accept;
    logic             req_bad;

    assign accept  = req_valid && req_ready;
    assign req_bad = is_bad_req(req_store, req_funct3, req_addr[1:0]);

    lsu_lane_align #(.WIDTH(WIDTH)) u_align (
        .old_word  (old_r),
        .rd_word   (mem_out_data),
        .wdata     (wdata_r),
        .lane      (addr_r[1:0]),
        .funct3    (funct3_r),
        .merged    (merged),
        .load_data (load_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_bad)
                        state_d = S_ERR;
                    else if (req_store && req_funct3 == F3_W)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD:    state_d = store_r ? S_WR : S_RESP;
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_r      <= '0;
            wdata_r     <= '0;
            funct3_r    <= '0;
            store_r     <= 1'b0;
            old_r       <= '0;
            resp_data_r <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_r   <= req_addr;
                wdata_r  <= req_wdata;
                funct3_r <= req_funct3;
                store_r  <= req_store;
                if (req_bad)
                    resp_data_r <= '0;
            end
            // The RD cycle feeds either the merge (store) or the response (load).
            if (state_q == S_RD) begin
                if (store_r)
                    old_r <= mem_out_data;
                else
                    resp_data_r <= load_data;
            end
            if (state_q == S_WR)
                resp_data_r <= '0;
        end
    end

    // All strobes are masked by rst so an in-flight op is dropped at once.
    assign req_ready      = (state_q == S_IDLE) && !rst;
    assign resp_valid     = ((state_q == S_RESP) || (state_q == S_ERR)) && !rst;
    assign resp_err       = (state_q == S_ERR) && !rst;
    assign resp_data      = resp_data_r;
    assign mem_read_en    = (state_q == S_RD) && !rst;
    assign mem_write_en   = (state_q == S_WR) && !rst;
    assign mem_addr       = ((state_q == S_RD) || (state_q == S_WR))
                            ? ((addr_r >> 2) + WIDTH'(ADDR_OFFSET)) : '0;
    assign mem_write_data = (state_q == S_WR) ? merged : '0;

endmodule

// File: tb/tb_lsu_engine.sv
// Directed bench for lsu_engine against a small behavioural word memory.
module tb_lsu_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_data;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_out_data;

    logic [31:0] mem [0:63];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;

    int checks = 0;
    int errors = 0;

    lsu_engine #(.WIDTH(32), .ADDR_OFFSET(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_err       (resp_err),
        .resp_data      (resp_data),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_out_data   (mem_out_data)
    );

    always #5 clk = ~clk;

    assign mem_out_data = mem[mem_addr[5:0]];

    always @(posedge clk) begin
        if (mem_write_en) begin
            mem[mem_addr[5:0]] <= mem_write_data;
            wr_cnt     = wr_cnt + 1;
            last_waddr = mem_addr;
            last_wdata = mem_write_data;
        end
        if (mem_read_en)
            rd_cnt = rd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request from an idle cycle; returns latency and the response.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat,
                         output logic [31:0] data, output logic err);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        data = resp_data;
        err  = resp_err;
        @(posedge clk);
        #1;
        chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
        chk("ready_after_resp", {31'd0, req_ready}, 32'd1);
    endtask

    int          lat;
    logic [31:0] d;
    logic        e;
    int          wc;
    int          rc;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;

        // Test 1: reset
        repeat (2) @(posedge clk);
        #1;
        chk("ready_in_reset", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", {31'd0, req_ready}, 32'd1);
        chk("resp_valid_reset", {31'd0, resp_valid}, 32'd0);
        chk("mem_rd_reset", {31'd0, mem_read_en}, 32'd0);
        chk("mem_wr_reset", {31'd0, mem_write_en}, 32'd0);
        chk("mem_addr_reset", mem_addr, 32'd0);
        chk("mem_wdata_reset", mem_write_data, 32'd0);
        chk("resp_data_reset", resp_data, 32'd0);
        chk("no_mem_activity", wr_cnt + rd_cnt, 32'd0);

        // Test 2: SW then LW
        issue(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, lat, d, e);
        chk("sw_lat", lat, 2);
        chk("sw_err", {31'd0, e}, 32'd0);
        chk("sw_data", d, 32'd0);
        chk("sw_waddr", last_waddr, 32'd3);
        chk("sw_wdata", last_wdata, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h8, 32'h0, lat, d, e);
        chk("lw_lat", lat, 2);
        chk("lw_data", d, 32'hDEADBEEF);
        chk("lw_held", resp_data, 32'hDEADBEEF);

        // Test 3: SB read-modify-write
        issue(1'b1, 3'b000, 32'h9, 32'h00000012, lat, d, e);
        chk("sb_lat", lat, 3);
        chk("sb_data_cleared", d, 32'd0);
        chk("sb_wdata", last_wdata, 32'hDEAD12EF);
        issue(1'b0, 3'b010, 32'h8, 32'h0, lat, d, e);
        chk("lw_after_sb", d, 32'hDEAD12EF);

        // Test 4: load extension
        issue(1'b1, 3'b010, 32'h0, 32'h80FF7F01, lat, d, e);
        chk("sw0_waddr", last_waddr, 32'd1);
        issue(1'b0, 3'b000, 32'h3, 32'h0, lat, d, e);
        chk("lb_3", d, 32'hFFFFFF80);
        issue(1'b0, 3'b100, 32'h3, 32'h0, lat, d, e);
        chk("lbu_3", d, 32'h00000080);
        issue(1'b0, 3'b001, 32'h2, 32'h0, lat, d, e);
        chk("lh_2", d, 32'hFFFF80FF);
        chk("lh_lat", lat, 2);
        issue(1'b0, 3'b101, 32'h0, 32'h0, lat, d, e);
        chk("lhu_0", d, 32'h00007F01);
        issue(1'b0, 3'b000, 32'h0, 32'h0, lat, d, e);
        chk("lb_0", d, 32'h00000001);
        issue(1'b0, 3'b001, 32'h0, 32'h0, lat, d, e);
        chk("lh_0", d, 32'h00007F01);
        issue(1'b1, 3'b001, 32'h2, 32'h0000CAFE, lat, d, e);
        chk("sh_hi_lat", lat, 3);
        chk("sh_hi_wdata", last_wdata, 32'hCAFE7F01);

        // Test 5: misaligned and illegal requests
        wc = wr_cnt;
        rc = rd_cnt;
        issue(1'b0, 3'b010, 32'h6, 32'h0, lat, d, e);
        chk("lw6_lat", lat, 1);
        chk("lw6_err", {31'd0, e}, 32'd1);
        chk("lw6_data", d, 32'd0);
        issue(1'b1, 3'b001, 32'h1, 32'h1234, lat, d, e);
        chk("sh1_lat", lat, 1);
        chk("sh1_err", {31'd0, e}, 32'd1);
        issue(1'b1, 3'b100, 32'h0, 32'h55, lat, d, e);
        chk("sbu_err", {31'd0, e}, 32'd1);
        chk("err_no_write", wr_cnt, wc);
        chk("err_no_read", rd_cnt, rc);
        chk("err_mem_unchanged", mem[3], 32'hDEAD12EF);
        issue(1'b0, 3'b010, 32'h8, 32'h0, lat, d, e);
        chk("ok_after_err", {31'd0, e}, 32'd0);

        // Test 6: reset during the WR cycle of a halfword store
        issue(1'b1, 3'b010, 32'h4, 32'h11223344, lat, d, e);
        wc = wr_cnt;
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h4;
        req_wdata  = 32'h0000BEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("sh4_rd_en", {31'd0, mem_read_en}, 32'd1);
        @(posedge clk);
        #1;
        chk("sh4_wr_en", {31'd0, mem_write_en}, 32'd1);
        chk("sh4_addr", mem_addr, 32'd2);
        chk("sh4_merge", mem_write_data, 32'h1122BEEF);
        rst = 1'b1;
        #1;
        chk("sh4_wr_gated", {31'd0, mem_write_en}, 32'd0);
        chk("sh4_no_resp", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("sh4_idle_ready", {31'd0, req_ready}, 32'd1);
        chk("sh4_no_resp_after", {31'd0, resp_valid}, 32'd0);
        chk("sh4_no_write", wr_cnt, wc);
        @(posedge clk);
        #1;
        chk("sh4_still_no_resp", {31'd0, resp_valid}, 32'd0);
        issue(1'b0, 3'b010, 32'h4, 32'h0, lat, d, e);
        chk("lw4_old_word", d, 32'h11223344);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
